// File: rtl/cpu.sv
// Multicycle RV32I-subset core: unified word memory, 32x32 register file,
// and a one-state-per-step control FSM that retires through DONE.
package cpu_pkg;
    typedef enum logic [4:0] {
        S_FETCH  = 5'd0,  S_DECODE = 5'd1,  S_EXEC_R = 5'd2,  S_EXEC_I = 5'd3,
        S_ADDR   = 5'd4,  S_MEM_RD = 5'd5,  S_MEM_WB = 5'd6,  S_MEM_WR = 5'd7,
        S_BRANCH = 5'd8,  S_JAL    = 5'd9,  S_JALR   = 5'd10, S_LUI    = 5'd11,
        S_AUIPC  = 5'd12, S_ALU_WB = 5'd13, S_DONE   = 5'd16, S_HALT   = 5'd17
    } state_t;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
endpackage

module regfile (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] regMemory [0:31];

    always_ff @(posedge i_clk)
        if (i_we && i_wa != 5'd0) regMemory[i_wa] <= i_wd;

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : regMemory[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : regMemory[i_ra2];
endmodule

module memory_unit #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wd,
    output logic [31:0]   o_rd
);
    logic [31:0] memory [0:MEM_WORDS-1];

    always_ff @(posedge i_clk)
        if (i_we) memory[i_idx] <= i_wd;

    assign o_rd = memory[i_idx];
endmodule

module control_unit (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [6:0]      i_opcode,
    output cpu_pkg::state_t o_state
);
    import cpu_pkg::*;
    state_t state, w_next;

    always_ff @(posedge i_clk)
        if (i_rst) state <= S_FETCH;
        else       state <= w_next;

    always_comb begin
        w_next = S_FETCH;
        case (state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_R:                w_next = S_EXEC_R;
                    OP_I:                w_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:   w_next = S_ADDR;
                    OP_BRANCH:           w_next = S_BRANCH;
                    OP_JAL:              w_next = S_JAL;
                    OP_JALR:             w_next = S_JALR;
                    OP_LUI:              w_next = S_LUI;
                    OP_AUIPC:            w_next = S_AUIPC;
                    default:             w_next = S_HALT;
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
            S_ADDR:   w_next = (i_opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: w_next = S_MEM_WB;
            S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_JALR,
            S_LUI, S_AUIPC, S_ALU_WB: w_next = S_DONE;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    assign o_state = state;
endmodule

module cpu #(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    import cpu_pkg::*;
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] instr, r_pc, r_a, r_b, r_alu, r_mdr;
    logic [31:0] w_rs1, w_rs2, w_imm, w_pc4, w_pcimm, w_maddr, w_mrd, w_rf_wd;
    logic        w_rf_we, w_taken;
    logic [2:0]  w_f3;
    state_t      w_state;

    assign w_f3    = instr[14:12];
    assign w_pc4   = r_pc + 32'd4;
    assign w_pcimm = r_pc + w_imm;
    assign w_maddr = (w_state == S_FETCH) ? r_pc : r_alu;

    control_unit CU (.i_clk(clk), .i_rst(rst), .i_opcode(instr[6:0]), .o_state(w_state));

    regfile r (
        .i_clk(clk), .i_we(w_rf_we), .i_ra1(instr[19:15]), .i_ra2(instr[24:20]),
        .i_wa(instr[11:7]), .i_wd(w_rf_wd), .o_rd1(w_rs1), .o_rd2(w_rs2)
    );

    memory_unit #(.MEM_WORDS(MEM_WORDS), .AW(AW)) mem (
        .i_clk(clk), .i_we(!rst && w_state == S_MEM_WR), .i_idx(w_maddr[AW+1:2]),
        .i_wd(r_b), .o_rd(w_mrd)
    );

    always_comb begin
        case (instr[6:0])
            OP_STORE:        w_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:       w_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_JAL:          w_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            OP_LUI, OP_AUIPC: w_imm = {instr[31:12], 12'd0};
            default:         w_imm = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

    always_comb begin
        case (w_f3)
            3'b000:  w_taken = (r_a == r_b);
            3'b001:  w_taken = (r_a != r_b);
            3'b100:  w_taken = ($signed(r_a) <  $signed(r_b));
            3'b101:  w_taken = ($signed(r_a) >= $signed(r_b));
            3'b110:  w_taken = (r_a <  r_b);
            3'b111:  w_taken = (r_a >= r_b);
            default: w_taken = 1'b0;
        endcase
    end

    // alt selects SUB / arithmetic right shift
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  alu = alt ? a - b : a + b;
            3'b001:  alu = a << b[4:0];
            3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
            3'b011:  alu = {31'd0, a < b};
            3'b100:  alu = a ^ b;
            3'b101:  alu = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    always_comb begin
        w_rf_we = 1'b0;
        w_rf_wd = r_alu;
        case (w_state)
            S_MEM_WB:      begin w_rf_we = 1'b1; w_rf_wd = r_mdr;   end
            S_JAL, S_JALR: begin w_rf_we = 1'b1; w_rf_wd = w_pc4;   end
            S_LUI:         begin w_rf_we = 1'b1; w_rf_wd = w_imm;   end
            S_AUIPC:       begin w_rf_we = 1'b1; w_rf_wd = w_pcimm; end
            S_ALU_WB:      begin w_rf_we = 1'b1; w_rf_wd = r_alu;   end
            default: ;
        endcase
        // a reset edge must never commit a half-finished instruction
        if (rst) w_rf_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_PC;
            instr <= 32'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_alu <= 32'd0;
            r_mdr <= 32'd0;
        end else begin
            case (w_state)
                S_FETCH:  instr <= w_mrd;
                S_DECODE: begin r_a <= w_rs1; r_b <= w_rs2; end
                S_EXEC_R: r_alu <= alu(w_f3, instr[30], r_a, r_b);
                S_EXEC_I: r_alu <= alu(w_f3, (w_f3 == 3'b101) && instr[30], r_a, w_imm);
                S_ADDR:   r_alu <= r_a + w_imm;
                S_MEM_RD: r_mdr <= w_mrd;
                S_MEM_WB, S_MEM_WR, S_LUI, S_AUIPC, S_ALU_WB: r_pc <= w_pc4;
                S_BRANCH: r_pc <= w_taken ? w_pcimm : w_pc4;
                S_JAL:    r_pc <= w_pcimm;
                S_JALR:   r_pc <= (r_a + w_imm) & ~32'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Directed and randomized programs for the multicycle core, checked against an
// instruction-level reference interpreter.
module tb_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] img    [256];
    logic [31:0] r_init [32];
    logic [31:0] m_mem  [256];
    logic [31:0] m_reg  [32];
    logic [31:0] m_pc;

    localparam logic [31:0] ECALL = 32'h0000_0073;

    cpu dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    function automatic logic [31:0] e_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] e_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
        return {12'(imm), 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] e_s(input int imm, input int rs2, input int rs1);
        logic [11:0] v;
        v = 12'(imm);
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
        logic [12:0] v;
        v = 13'(imm);
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] e_j(input int imm, input int rd);
        logic [20:0] v;
        v = 21'(imm);
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
    endfunction

    // Reference interpreter: executes one instruction at m_pc with ISA semantics.
    task automatic model_step(output bit halt, output int lat);
        logic [31:0] ins, a, b, bb, iI, iS, iB, iJ, iU, res, npc, ea;
        logic [2:0] f3;
        int sh;
        bit wr, tk;
        ins = m_mem[m_pc[9:2]];
        a = m_reg[ins[19:15]]; b = m_reg[ins[24:20]]; f3 = ins[14:12];
        iI = {{20{ins[31]}}, ins[31:20]};
        iS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        iB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        iU = {ins[31:12], 12'd0};
        npc = m_pc + 4; wr = 0; res = 0; halt = 0; lat = 4; tk = 0;
        case (ins[6:0])
            7'h33, 7'h13: begin
                bb = (ins[6:0] == 7'h33) ? b : iI;
                sh = int'(bb[4:0]);
                lat = 5; wr = 1;
                case (f3)
                    3'd0: res = (ins[6:0] == 7'h33 && ins[30]) ? a - bb : a + bb;
                    3'd1: res = a << sh;
                    3'd2: res = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < bb) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ bb;
                    3'd5: res = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
                    3'd6: res = a | bb;
                    default: res = a & bb;
                endcase
            end
            7'h03: begin ea = a + iI; res = m_mem[ea[9:2]]; wr = 1; lat = 6; end
            7'h23: begin ea = a + iS; m_mem[ea[9:2]] = b; lat = 5; end
            7'h63: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 0;
                endcase
                if (tk) npc = m_pc + iB;
            end
            7'h6F: begin res = m_pc + 4; wr = 1; npc = m_pc + iJ; end
            7'h67: begin res = m_pc + 4; wr = 1; npc = (a + iI) & ~32'd1; end
            7'h37: begin res = iU; wr = 1; end
            7'h17: begin res = m_pc + iU; wr = 1; end
            default: halt = 1;
        endcase
        if (wr && ins[11:7] != 5'd0) m_reg[ins[11:7]] = res;
        if (!halt) m_pc = npc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin dut.mem.memory[i] = img[i]; m_mem[i] = img[i]; end
        for (int i = 0; i < 32; i++) begin dut.r.regMemory[i] = r_init[i]; m_reg[i] = r_init[i]; end
        dut.r.regMemory[0] = 32'd0; m_reg[0] = 32'd0; m_pc = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs until the next DONE; cyc counts FETCH..DONE inclusive.
    task automatic retire(output int cyc, output bit ok);
        if (dut.CU.state == 5'd16) @(negedge clk);
        cyc = 1; ok = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            cyc++;
            if (dut.CU.state == 5'd16) begin ok = 1; break; end
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'd0;
        for (int i = 0; i < 32; i++) r_init[i] = 32'd0;
    endtask

    task automatic test_reset();
        int exp_seq [6] = '{0, 1, 3, 13, 16, 0};
        logic [4:0] st;
        clear_img();
        img[0] = e_i(5, 0, 3'd0, 1, 7'h13);
        img[1] = ECALL;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            st = dut.CU.state;
            n_chk++;
            if (st !== 5'(exp_seq[i])) $display("FAIL reset_seq[%0d] state got %0d want %0d", i, st, exp_seq[i]);
            else n_pass++;
            if (i == 1) begin
                n_chk++;
                if (dut.instr !== img[0]) $display("FAIL reset_fetch instr got %h want %h", dut.instr, img[0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_alu();
        int cyc; bit ok;
        logic [31:0] exp_r [4] = '{32'd5, 32'd7, 32'h0000_000C, 32'hFFFF_FFFE};
        clear_img();
        img[0] = e_i(5, 0, 3'd0, 1, 7'h13);
        img[1] = e_i(7, 0, 3'd0, 2, 7'h13);
        img[2] = e_r(7'h00, 2, 1, 3'd0, 3);
        img[3] = e_r(7'h20, 2, 1, 3'd0, 4);
        img[4] = ECALL;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            retire(cyc, ok);
            n_chk++;
            if (!ok || cyc != 5) $display("FAIL alu_latency[%0d] cycles got %0d want 5 (done=%0d)", i, cyc, ok);
            else n_pass++;
            n_chk++;
            if (dut.r.regMemory[i+1] !== exp_r[i])
                $display("FAIL alu_x%0d got %h want %h", i + 1, dut.r.regMemory[i+1], exp_r[i]);
            else n_pass++;
        end
    endtask

    task automatic test_mem();
        int cyc; bit ok;
        clear_img();
        img[0] = e_j(12, 0);
        img[3] = e_i(12, 0, 3'd0, 3, 7'h13);
        img[4] = e_s(8, 3, 0);
        img[5] = e_i(8, 0, 3'd2, 5, 7'h03);
        img[6] = ECALL;
        do_reset();
        retire(cyc, ok);
        retire(cyc, ok);
        retire(cyc, ok);
        n_chk++;
        if (!ok || cyc != 5) $display("FAIL sw_latency cycles got %0d want 5", cyc); else n_pass++;
        n_chk++;
        if (dut.mem.memory[2] !== 32'h0000_000C) $display("FAIL sw_data mem[2] got %h want 0000000c", dut.mem.memory[2]);
        else n_pass++;
        retire(cyc, ok);
        n_chk++;
        if (!ok || cyc != 6) $display("FAIL lw_latency cycles got %0d want 6", cyc); else n_pass++;
        n_chk++;
        if (dut.r.regMemory[5] !== 32'h0000_000C) $display("FAIL lw_data x5 got %h want 0000000c", dut.r.regMemory[5]);
        else n_pass++;
    endtask

    task automatic test_branch_jump();
        int cyc; bit ok;
        clear_img();
        img[0]  = e_i(1, 0, 3'd0, 1, 7'h13);
        img[1]  = e_b(8, 1, 1, 3'd0);
        img[2]  = e_i(99, 0, 3'd0, 7, 7'h13);
        img[3]  = e_i(3, 0, 3'd0, 8, 7'h13);
        img[4]  = e_j(16, 0);
        img[8]  = e_j(8, 6);
        img[9]  = e_i(98, 0, 3'd0, 7, 7'h13);
        img[10] = e_i(32'h40, 0, 3'd0, 10, 7'h13);
        img[11] = e_i(-8, 10, 3'd0, 10, 7'h67);
        img[12] = e_i(97, 0, 3'd0, 7, 7'h13);
        img[13] = e_i(97, 0, 3'd0, 7, 7'h13);
        img[14] = ECALL;
        do_reset();
        retire(cyc, ok);
        retire(cyc, ok);
        n_chk++;
        if (!ok || cyc != 4) $display("FAIL beq_latency cycles got %0d want 4", cyc); else n_pass++;
        retire(cyc, ok);
        n_chk++;
        if (dut.r.regMemory[8] !== 32'd3 || dut.r.regMemory[7] !== 32'd0)
            $display("FAIL beq_skip x8 got %h want 3, x7 got %h want 0", dut.r.regMemory[8], dut.r.regMemory[7]);
        else n_pass++;
        retire(cyc, ok);
        retire(cyc, ok);
        n_chk++;
        if (dut.r.regMemory[6] !== 32'h24) $display("FAIL jal_link x6 got %h want 00000024", dut.r.regMemory[6]);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_chk++;
        if (dut.instr !== img[10]) $display("FAIL jal_target instr got %h want %h (pc 0x28)", dut.instr, img[10]);
        else n_pass++;
        retire(cyc, ok);
        retire(cyc, ok);
        n_chk++;
        if (dut.r.regMemory[10] !== 32'h30) $display("FAIL jalr_link x10 got %h want 00000030", dut.r.regMemory[10]);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_chk++;
        if (dut.instr !== img[14]) $display("FAIL jalr_old_rs1 instr got %h want %h (pc 0x38)", dut.instr, img[14]);
        else n_pass++;
    endtask

    task automatic test_x0();
        int cyc; bit ok;
        clear_img();
        img[0] = e_i(9, 0, 3'd0, 0, 7'h13);
        img[1] = e_i(4, 0, 3'd0, 11, 7'h13);
        img[2] = ECALL;
        do_reset();
        retire(cyc, ok);
        n_chk++;
        if (dut.r.regMemory[0] !== 32'd0) $display("FAIL x0_write reg0 got %h want 0", dut.r.regMemory[0]);
        else n_pass++;
        retire(cyc, ok);
        n_chk++;
        if (dut.r.regMemory[11] !== 32'd4) $display("FAIL x0_read x11 got %h want 4", dut.r.regMemory[11]);
        else n_pass++;
    endtask

    task automatic test_halt();
        int cyc, bad; bit ok, hit;
        clear_img();
        img[0] = e_i(5, 0, 3'd0, 1, 7'h13);
        img[1] = ECALL;
        do_reset();
        retire(cyc, ok);
        hit = 0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (dut.CU.state == 5'd17) hit = 1;
        end
        n_chk++;
        if (!hit) $display("FAIL halt_enter state got %0d want 17", dut.CU.state); else n_pass++;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (dut.CU.state != 5'd17 || dut.r.regMemory[1] !== 32'd5) bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL halt_hold bad cycles got %0d want 0", bad); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (dut.CU.state !== 5'd0) $display("FAIL halt_reset state got %0d want 0", dut.CU.state); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (dut.instr !== img[0]) $display("FAIL halt_reset_pc instr got %h want %h", dut.instr, img[0]);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int cyc; bit ok, hit;
        clear_img();
        img[0] = e_i(32'h55, 0, 3'd0, 1, 7'h13);
        img[1] = e_s(16, 1, 0);
        img[2] = ECALL;
        do_reset();
        retire(cyc, ok);
        hit = 0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (dut.CU.state == 5'd7) hit = 1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (!hit || dut.mem.memory[4] !== 32'd0)
            $display("FAIL abort_sw mem[4] got %h want 0 (reached MEM_WR=%0d)", dut.mem.memory[4], hit);
        else n_pass++;
        n_chk++;
        if (dut.CU.state !== 5'd0) $display("FAIL abort_state got %0d want 0", dut.CU.state); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random(input int seed_iter);
        int cyc, lat, steps, badreg, badmem; bit ok, halt, hit;
        logic [2:0] f3;
        logic [2:0] bf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        int kind, rd, rs1, rs2;
        clear_img();
        for (int i = 1; i < 32; i++) r_init[i] = $urandom;
        for (int i = 128; i < 144; i++) img[i] = $urandom;
        for (int i = 0; i < 64; i++) begin
            kind = $urandom_range(0, 9);
            rd = $urandom_range(0, 7); rs1 = $urandom_range(1, 7); rs2 = $urandom_range(1, 7);
            f3 = 3'($urandom_range(0, 7));
            if (i >= 56) img[i] = ECALL;
            else if (kind <= 3)
                img[i] = e_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                             rs2, rs1, f3, rd);
            else if (kind <= 6) begin
                if (f3 == 3'd1) img[i] = e_i($urandom_range(0, 31), rs1, f3, rd, 7'h13);
                else if (f3 == 3'd5) img[i] = e_i($urandom_range(0, 31) + ($urandom_range(0, 1) * 32'h400), rs1, f3, rd, 7'h13);
                else img[i] = e_i($urandom_range(0, 4095), rs1, f3, rd, 7'h13);
            end
            else if (kind == 7)
                img[i] = {20'($urandom), 5'(rd), ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17};
            else if (kind == 8) begin
                if ($urandom_range(0, 1) == 1) img[i] = e_s(512 + 4 * $urandom_range(0, 15), rs2, 0);
                else img[i] = e_i(512 + 4 * $urandom_range(0, 15), 0, 3'd2, rd, 7'h03);
            end
            else img[i] = e_b(4 * $urandom_range(1, 3), rs2, rs1, bf3[$urandom_range(0, 5)]);
        end
        do_reset();
        steps = 0;
        forever begin
            model_step(halt, lat);
            if (halt || steps > 80) break;
            steps++;
            retire(cyc, ok);
            n_chk++;
            if (!ok || cyc != lat) $display("FAIL rnd%0d_latency step %0d got %0d want %0d", seed_iter, steps, cyc, lat);
            else n_pass++;
            badreg = -1;
            for (int j = 0; j < 32; j++) if (dut.r.regMemory[j] !== m_reg[j] && badreg < 0) badreg = j;
            n_chk++;
            if (badreg >= 0)
                $display("FAIL rnd%0d_regs step %0d x%0d got %h want %h", seed_iter, steps, badreg,
                         dut.r.regMemory[badreg], m_reg[badreg]);
            else n_pass++;
        end
        hit = 0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (dut.CU.state == 5'd17) hit = 1;
        end
        n_chk++;
        if (!hit) $display("FAIL rnd%0d_halt state got %0d want 17", seed_iter, dut.CU.state); else n_pass++;
        badmem = -1;
        for (int j = 128; j < 144; j++) if (dut.mem.memory[j] !== m_mem[j] && badmem < 0) badmem = j;
        n_chk++;
        if (badmem >= 0)
            $display("FAIL rnd%0d_mem word %0d got %h want %h", seed_iter, badmem, dut.mem.memory[badmem], m_mem[badmem]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch_jump();
        test_x0();
        test_halt();
        test_reset_abort();
        for (int s = 0; s < 6; s++) test_random(s);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Multicycle RV32I-subset processor core with internal unified instruction/data memory and register file; top of the core hierarchy.
- Ports are clock and reset only. Benches observe and initialise state through fixed hierarchical names:
  - register file instance `r`, array `regMemory[0:31]` (32-bit)
  - control unit instance `CU`, 5-bit register `state`
  - top-level 32-bit instruction register `instr`
  - memory instance `mem`, array `memory[0:255]` (32-bit words)

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the unified memory; word index = address[9:2].
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.

Behaviour:
- Reset (rst high at a posedge):
  - PC <= RESET_PC, CU.state <= 0 (FETCH), instr <= 0, internal A/B/ALUout/MDR <= 0.
  - Register file and memory are not reset; the bench initialises them.
- Register file:
  - 32 x 32-bit, two combinational read ports, one synchronous write port.
  - x0 reads 0 and ignores writes.
- Memory:
  - Word-aligned; address bits [1:0] are ignored.
  - Combinational read; write on posedge when in MEM_WR.
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - I-type ALU: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - LW, SW, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR, LUI, AUIPC, ECALL/EBREAK.
- Arithmetic: 32-bit wrap-around, no overflow trap. Shift amount is the low 5 bits. Immediates are sign-extended per RISC-V format.
- FSM states (5-bit encoding, decimal):
  - 0 FETCH: instr <= memory[PC]. Next: DECODE.
  - 1 DECODE: A <= rs1, B <= rs2, immediate formed. Dispatch by opcode to 2/3/4/8/9/10/11/12. ECALL, EBREAK or unknown opcode go to 17.
  - 2 EXEC_R: ALUout <= A op B. Next: 13.
  - 3 EXEC_I: ALUout <= A op imm. Next: 13.
  - 4 ADDR: ALUout <= A + imm. Next: 5 for LW, 7 for SW.
  - 5 MEM_RD: MDR <= memory[ALUout]. Next: 6.
  - 6 MEM_WB: rd <= MDR; PC <= PC+4. Next: 16.
  - 7 MEM_WR: memory[ALUout] <= B; PC <= PC+4. Next: 16.
  - 8 BRANCH: PC <= taken ? PC+imm : PC+4. Next: 16.
  - 9 JAL: rd <= PC+4; PC <= PC+imm. Next: 16.
  - 10 JALR: rd <= PC+4; PC <= (A+imm) & ~1. Next: 16.
  - 11 LUI: rd <= imm. PC <= PC+4. Next: 16.
  - 12 AUIPC: rd <= PC+imm. PC <= PC+4. Next: 16.
  - 13 ALU_WB: rd <= ALUout; PC <= PC+4. Next: 16.
  - 14, 15: unused; go to 0.
  - 16 DONE: retire cycle, exactly one per instruction. All architectural writes are visible. Next: 0.
  - 17 HALT: sticky until reset; no register, memory or PC changes.
- Latency in cycles, FETCH through DONE inclusive:
  - R/I-ALU, SW: 5
  - LW: 6
  - branch, JAL, JALR, LUI, AUIPC: 4
- Edge cases:
  - JALR with rd == rs1 uses the old rs1 value, latched in A.
  - rst asserted in any state, including HALT, aborts the instruction; no partial write occurs on that edge.
  - PC wraps modulo 2^32; memory index wraps modulo MEM_WORDS.

Test Plan:
- Reset: rst=1 for one posedge -> PC=0, CU.state=0. After release, CU.state sequence for ADDI is 0,1,3,13,16,0.
- ALU: ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2; SUB x4,x1,x2 -> x3=0000000C, x4=FFFFFFFE at state 16.
- Memory: SW x3,8(x0); LW x5,8(x0) -> memory[2]=0000000C, x5=0000000C; LW takes 6 cycles.
- Branch/jump:
  - BEQ x1,x1,+8 skips the next instruction.
  - JAL x6,+8 at PC=0x20 -> x6=00000024, PC=00000028.
- x0: ADDI x0,x0,9 -> regMemory[0] stays 0.
- Halt: ECALL -> state 17 and holds for 10 cycles with registers unchanged. rst then returns PC to 0 and state to 0.
